// File: rtl/t01_lineclear_multi_if.sv
// rtl/t01_lineclear_multi_if.sv - control, grid and score bundle for the line-clear engine
interface t01_lineclear_multi_if #(
  parameter int COLS    = 10,
  parameter int ROWS    = 20,
  parameter int CBITS   = 3,
  parameter int SCORE_W = 10
);
  logic                        clear;
  logic                        start_eval;
  logic [ROWS*COLS-1:0]        input_array;
  logic [ROWS*COLS*CBITS-1:0]  input_color_array;
  logic [ROWS*COLS-1:0]        output_array;
  logic [ROWS*COLS*CBITS-1:0]  output_color_array;
  logic                        busy;
  logic                        eval_done;
  logic [SCORE_W-1:0]          score;
  logic [2:0]                  lines_last;
  logic [9:0]                  lines_total;
  logic [3:0]                  level;

  modport master (
    output clear, start_eval, input_array, input_color_array,
    input  output_array, output_color_array, busy, eval_done,
           score, lines_last, lines_total, level
  );

  modport slave (
    input  clear, start_eval, input_array, input_color_array,
    output output_array, output_color_array, busy, eval_done,
           score, lines_last, lines_total, level
  );
endinterface

// File: rtl/t01_lineclear_multi.sv
// rtl/t01_lineclear_multi.sv - full-row removal with gravity shift and level-scaled scoring
module t01_lineclear_multi #(
  parameter int COLS            = 10,
  parameter int ROWS            = 20,
  parameter int CBITS           = 3,
  parameter int SCORE_W         = 10,
  parameter int SCORE_MAX       = 999,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  t01_lineclear_multi_if.slave  bus
);
  localparam int RW    = COLS * CBITS;
  localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SUM_W = ((SCORE_W > 9) ? SCORE_W : 9) + 1;

  typedef enum logic [2:0] {IDLE, SCAN, SHIFT, SCORE, DONE} state_t;

  state_t               state, state_nxt;
  logic [ROWS*COLS-1:0] occ;
  logic [ROWS*RW-1:0]   col;
  logic [PTR_W-1:0]     ptr;
  logic [2:0]           cnt;
  logic [SCORE_W-1:0]   score_q;
  logic [2:0]           last_q;
  logic [9:0]           total_q;

  logic                 row_full;
  logic [9:0]           level_raw;
  logic [3:0]           level_c;
  logic [3:0]           base;
  logic [8:0]           add;
  logic [SUM_W-1:0]     score_sum;
  logic [10:0]          total_sum;

  always_comb begin
    row_full = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (PTR_W'(r) == ptr) row_full = &occ[r*COLS +: COLS];
    end
  end

  // Level is derived from the registered total, so SCORE sees the pre-update value.
  assign level_raw = 10'(total_q / LINES_PER_LEVEL);
  assign level_c   = (level_raw > 10'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level_raw[3:0];

  always_comb begin
    base = 4'd0;
    case (cnt)
      3'd1:    base = 4'd1;
      3'd2:    base = 4'd3;
      3'd3:    base = 4'd5;
      3'd4:    base = 4'd8;
      default: base = 4'd0;
    endcase
  end

  assign add       = 9'(base) * (9'(level_c) + 9'd1);
  assign score_sum = SUM_W'(score_q) + SUM_W'(add);
  assign total_sum = 11'(total_q) + 11'(cnt);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start_eval) state_nxt = SCAN;
      SCAN: begin
        if (row_full)        state_nxt = SHIFT;
        else if (ptr == '0)  state_nxt = SCORE;
      end
      SHIFT: state_nxt = SCAN;
      SCORE: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ     <= '0;
      col     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      score_q <= '0;
      last_q  <= '0;
      total_q <= '0;
    end else if (bus.clear) begin
      occ     <= '0;
      col     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      score_q <= '0;
      last_q  <= '0;
      total_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_eval) begin
          occ <= bus.input_array;
          col <= bus.input_color_array;
          ptr <= PTR_W'(ROWS - 1);
          cnt <= '0;
        end
        SCAN: if (!row_full && ptr != '0) ptr <= ptr - 1'b1;
        SHIFT: begin
          // ptr is held so the row that just dropped into it is checked again.
          for (int k = 1; k < ROWS; k++) begin
            if (PTR_W'(k) <= ptr) begin
              occ[k*COLS +: COLS] <= occ[(k-1)*COLS +: COLS];
              col[k*RW +: RW]     <= col[(k-1)*RW +: RW];
            end
          end
          occ[0 +: COLS] <= '0;
          col[0 +: RW]   <= '0;
          if (cnt != 3'd4) cnt <= cnt + 3'd1;
        end
        SCORE: begin
          score_q <= (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];
          total_q <= (total_sum > 11'd1023) ? 10'd1023 : total_sum[9:0];
          last_q  <= cnt;
        end
        default: ;
      endcase
    end
  end

  assign bus.output_array       = occ;
  assign bus.output_color_array = col;
  assign bus.busy               = (state != IDLE);
  assign bus.eval_done          = (state == DONE);
  assign bus.score              = score_q;
  assign bus.lines_last         = last_q;
  assign bus.lines_total        = total_q;
  assign bus.level              = level_c;
endmodule

// File: tb/tb_t01_lineclear_multi.sv
// tb/tb_t01_lineclear_multi.sv - randomized bench with a row-list reference model
module tb_t01_lineclear_multi;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int CBITS = 3;
  localparam int SCORE_W = 10;
  localparam int RW = COLS * CBITS;
  localparam int OW = ROWS * COLS;
  localparam int CW = ROWS * RW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  t01_lineclear_multi_if #(.COLS(COLS), .ROWS(ROWS), .CBITS(CBITS), .SCORE_W(SCORE_W)) bus ();

  t01_lineclear_multi #(
    .COLS(COLS), .ROWS(ROWS), .CBITS(CBITS), .SCORE_W(SCORE_W),
    .SCORE_MAX(999), .LINES_PER_LEVEL(10), .MAX_LEVEL(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass = 0;
  int m_score = 0;
  int m_total = 0;
  int m_last = 0;
  logic [OW-1:0] b_occ;
  logic [CW-1:0] b_col;

  task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int m_level();
    int l;
    l = m_total / 10;
    return (l > 15) ? 15 : l;
  endfunction

  // Reference: keep every non-full row in bottom-up order, then stack them from the floor.
  task automatic model_eval(input logic [OW-1:0] oi, input logic [CW-1:0] ci,
                            output logic [OW-1:0] oo, output logic [CW-1:0] co, output int n);
    int dst;
    n = 0; oo = '0; co = '0; dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (&oi[r*COLS +: COLS]) n++;
      else begin
        oo[dst*COLS +: COLS] = oi[r*COLS +: COLS];
        co[dst*RW +: RW] = ci[r*RW +: RW];
        dst--;
      end
    end
  endtask

  task automatic run_eval(input string tag, input logic [OW-1:0] oi, input logic [CW-1:0] ci);
    logic [OW-1:0] eo;
    logic [CW-1:0] ec;
    int n, c, k, busy_cnt, add;
    int base_tab[5] = '{0, 1, 3, 5, 8};
    model_eval(oi, ci, eo, ec, n);
    c = (n > 4) ? 4 : n;
    add = base_tab[c] * (m_level() + 1);
    m_score = (m_score + add > 999) ? 999 : m_score + add;
    m_total = (m_total + c > 1023) ? 1023 : m_total + c;
    m_last = c;
    bus.input_array = oi;
    bus.input_color_array = ci;
    bus.start_eval = 1'b1;
    @(posedge clk); #1;
    bus.start_eval = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    k = 0;
    while (!bus.eval_done && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (bus.busy) busy_cnt++;
    end
    check({tag, "_latency"}, k, ROWS + 2*n + 1);
    check({tag, "_busy_cycles"}, busy_cnt, ROWS + 2*n + 2);
    check({tag, "_occ"}, bus.output_array, eo);
    check({tag, "_col"}, bus.output_color_array, ec);
    check({tag, "_score"}, bus.score, m_score);
    check({tag, "_last"}, bus.lines_last, m_last);
    check({tag, "_total"}, bus.lines_total, m_total);
    check({tag, "_level"}, bus.level, m_level());
    @(posedge clk); #1;
    check({tag, "_busy_fall"}, {bus.busy, bus.eval_done}, 2'b00);
    check({tag, "_occ_held"}, bus.output_array, eo);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    m_score = 0; m_total = 0; m_last = 0;
  endtask

  task automatic tetris_board(output logic [OW-1:0] o, output logic [CW-1:0] c);
    o = '0;
    for (int r = 0; r < ROWS; r++) c[r*RW +: RW] = RW'($urandom);
    for (int r = 16; r < 20; r++) o[r*COLS +: COLS] = '1;
  endtask

  task automatic rand_board(output logic [OW-1:0] o, output logic [CW-1:0] c);
    for (int r = 0; r < ROWS; r++) begin
      o[r*COLS +: COLS] = ($urandom_range(0, 3) == 0) ? {COLS{1'b1}} : COLS'($urandom);
      c[r*RW +: RW] = RW'($urandom);
    end
  endtask

  initial begin
    int it, pulses;
    logic [COLS-1:0] r18;
    bus.clear = 1'b0;
    bus.start_eval = 1'b0;
    bus.input_array = '0;
    bus.input_color_array = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_occ", bus.output_array, 0);
    check("rst_col", bus.output_color_array, 0);
    check("rst_flags", {bus.busy, bus.eval_done}, 2'b00);
    check("rst_score", bus.score, 0);
    check("rst_lines", {bus.lines_last, bus.lines_total, bus.level}, 0);

    b_occ = '0;
    for (int r = 0; r < ROWS; r++) b_col[r*RW +: RW] = RW'($urandom);
    run_eval("empty", b_occ, b_col);

    b_occ = '0;
    b_col = '0;
    b_occ[19*COLS +: COLS] = '1;
    r18 = 10'b1011001101;
    b_occ[18*COLS +: COLS] = r18;
    b_col[18*RW +: RW] = {COLS{3'b101}};
    b_occ[5*COLS +: COLS] = 10'b0000110000;
    run_eval("single", b_occ, b_col);
    check("single_row19", bus.output_array[19*COLS +: COLS], r18);
    check("single_row19_col", bus.output_color_array[19*RW +: RW], {COLS{3'b101}});
    check("single_score_abs", bus.score, 1);

    rand_board(b_occ, b_col);
    for (int r = 0; r < 16; r++) b_occ[r*COLS +: COLS] = '0;
    b_occ[19*COLS +: COLS] = '1;
    b_occ[17*COLS +: COLS] = '1;
    b_occ[18*COLS +: COLS] = 10'b0101010101;
    b_occ[16*COLS +: COLS] = 10'b1100000011;
    run_eval("noncontig", b_occ, b_col);
    check("noncontig_row19", bus.output_array[19*COLS +: COLS], 10'b0101010101);
    check("noncontig_row18", bus.output_array[18*COLS +: COLS], 10'b1100000011);
    check("noncontig_score_abs", bus.score, 4);

    tetris_board(b_occ, b_col);
    run_eval("tetris", b_occ, b_col);
    b_occ = '0;
    run_eval("after_tetris", b_occ, b_col);

    for (int i = 0; i < 20; i++) begin
      rand_board(b_occ, b_col);
      run_eval("rand", b_occ, b_col);
    end

    do_clear();
    check("clear_score", bus.score, 0);
    tetris_board(b_occ, b_col);
    run_eval("lvl_t1", b_occ, b_col);
    run_eval("lvl_t2", b_occ, b_col);
    b_occ = '0;
    b_occ[19*COLS +: COLS] = '1;
    b_occ[18*COLS +: COLS] = '1;
    run_eval("lvl_double", b_occ, b_col);
    check("lvl_is_1", bus.level, 1);
    b_occ[18*COLS +: COLS] = '0;
    run_eval("lvl_single", b_occ, b_col);
    check("lvl_single_score_abs", bus.score, 21);

    it = 0;
    tetris_board(b_occ, b_col);
    while (m_score < 999 && it < 60) begin
      run_eval("sat_score", b_occ, b_col);
      it++;
    end
    check("score_saturated", bus.score, 999);
    it = 0;
    while (m_total < 1023 && it < 300) begin
      run_eval("sat_lines", b_occ, b_col);
      it++;
    end
    check("lines_saturated", bus.lines_total, 1023);
    check("level_saturated", bus.level, 15);

    b_occ[19*COLS +: COLS] = '1;
    bus.input_array = b_occ;
    bus.input_color_array = b_col;
    bus.start_eval = 1'b1;
    @(posedge clk); #1;
    bus.start_eval = 1'b0;
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    m_score = 0; m_total = 0; m_last = 0;
    check("mid_clear_busy", bus.busy, 0);
    check("mid_clear_occ", bus.output_array, 0);
    check("mid_clear_col", bus.output_color_array, 0);
    check("mid_clear_regs", {bus.score, bus.lines_last, bus.lines_total, bus.level}, 0);
    pulses = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (bus.eval_done) pulses++;
    end
    check("mid_clear_no_done", pulses, 0);

    bus.input_array = '0;
    bus.start_eval = 1'b1;
    pulses = 0;
    for (int e = 0; e < 69; e++) begin
      @(posedge clk); #1;
      if (bus.eval_done) pulses++;
      if (e == 68) bus.start_eval = 1'b0;
    end
    check("held_start_pulses", pulses, 3);
    @(posedge clk); #1;
    check("held_start_idle", bus.busy, 0);
    check("held_start_last", bus.lines_last, 0);

    b_occ = '0;
    b_occ[19*COLS +: COLS] = '1;
    run_eval("pre_reset", b_occ, b_col);
    bus.start_eval = 1'b1;
    @(posedge clk); #1;
    bus.start_eval = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_occ", bus.output_array, 0);
    check("async_rst_regs", {bus.score, bus.lines_last, bus.lines_total, bus.level}, 0);
    @(posedge clk); #1 reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
